jt10_adpcm_fetch: RTL and testbench
===================================

Name: jt10_adpcm_fetch

Overview:
ADPCM-A ROM fetch stage, directly downstream of the ADPCM-A address counter. It consumes the counter's stage-1 outputs (nibble address, bank, nibble select, read strobe, decode enable, section clear) and drives a single-port sample-ROM request/acknowledge interface. It buffers one byte per channel and emits the selected 4-bit sample, aligned to the channel rotation, to the ADPCM-A decoder.

Parameters:
LAT, 6, cen periods from request slot to nibble output; equals the channel count so output lands in the same channel slot one rotation later.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
cen  in  1  channel-slot enable, 666 kHz
cur_ch  in  6  one-hot current channel, rotates every cen
addr  in  20  byte address within bank, from the counter
bank  in  4  ROM bank, from the counter
sel  in  1  nibble select; 0 = high nibble, 1 = low nibble
roe_n  in  1  read strobe, active low, from the counter
decon  in  1  decode enable for this slot
clr  in  1  section start/stop for this slot
rom_addr  out  24  {bank, addr} of the outstanding request
rom_cs  out  1  request; held high until rom_ok or abandonment
rom_data  in  8  ROM byte, valid when rom_ok=1
rom_ok  in  1  acknowledge, sampled every clk
data  out  4  sample nibble to the decoder
dvalid  out  1  nibble valid (delayed decon)
dclr  out  1  delayed clr for the decoder
miss  out  6  per-channel sticky late-ROM flag

Behaviour:
- Reset values: rom_addr=0, rom_cs=0, data=0, dvalid=0, dclr=0, miss=0, all byte buffers=0, pending=0, pipeline contents=0.
- Slot index: a 3-bit encoding of cur_ch (bit0→0 … bit5→5). A non-one-hot cur_ch encodes as 7, which suppresses fetch and buffer writes for that slot.
- Fetch, evaluated on clk with cen=1:
  - roe_n=0, sel=0, slot≤5: rom_addr<={bank,addr}; rom_cs<=1; pending<=1; tag<=slot.
  - roe_n=0, sel=1: no ROM access; the low nibble comes from the buffered byte.
- Acknowledge, any clk: if pending and rom_ok, buf[tag]<=rom_data, rom_cs<=0, pending<=0. rom_ok while not pending is ignored.
- Late ROM: if pending is still set at the next cen, miss[tag]<=1 and buf[tag] keeps its old value. The old request is dropped that cycle; a new request from the current slot, if any, is issued in the same cycle. rom_ok and cen in the same clk: the acknowledge wins and no miss is flagged.
- clr, on cen with clr=1 and slot≤5:
  - buf[slot]<=0 and miss[slot]<=0.
  - A pending fetch with tag==slot is abandoned without setting miss.
  - If the same slot also requests, the request proceeds.
- Pipeline: a LAT-deep shift register, advanced on cen, carries {slot, sel, decon, clr}. At the output stage, on cen:
  - data<= sel ? buf[slot][3:0] : buf[slot][7:4]
  - dvalid<=decon; dclr<=clr
  - Outputs hold between cens.
- Output timing: a request issued at cen k yields its nibble at cen k+LAT. The ROM must acknowledge within one cen period, i.e. before cen k+1.
- Async reset mid-request: rom_cs drops immediately and the pending request is forgotten.

Decomposition:
- Shared jt10 ADPCM package holds: channel count (6), ROM address width (24), and the one-hot-to-index encode function, also usable by the counter.
- One sub-module, jt10_adpcm_fetch_pipe: the cen-advanced LAT-stage shift register for {slot, sel, decon, clr}.

Test Plan:
- Single fetch: ch0 slot with bank=4'h2, addr=20'h00013, sel=0, roe_n=0; ROM returns 8'hA7 after 3 clk → rom_addr=24'h200013, rom_cs high for 3 clk; 6 cens later data=4'hA, dvalid=1. Next ch0 rotation with sel=1 → data=4'h7, no rom_cs.
- Late ROM: ch2 request with rom_ok withheld past the next cen → miss=6'b000100, buf[2] unchanged (previous 8'h3C gives data=4'h3); ch3 request is issued in that same cen.
- clr flush: buf[1]=8'hFF, miss[1]=1, then clr=1 on the ch1 slot → buf[1]=0, miss[1]=0, next ch1 output data=0, dclr=1 six cens later.
- Collision: rom_ok and cen in the same clk for pending ch4 with rom_data=8'h5E → buf[4]=8'h5E, miss[4]=0.
- Reset mid-request: assert rst_n=0 while rom_cs=1 → rom_cs=0 in the same clk. After release, a stray rom_ok with rom_data=8'h99 writes no buffer; all outputs read 0.
- Bad cur_ch=6'b000011 with roe_n=0, sel=0 → no rom_cs and no buffer write.

Source files
------------

// File: rtl/jt10_adpcm_fetch_pkg.sv
// jt10_adpcm_fetch_pkg: shared ADPCM-A constants, pipeline entry type and channel encoder
package jt10_adpcm_fetch_pkg;
  localparam int NCH = 6;
  localparam int AW  = 24;
  typedef struct packed {
    logic [2:0] slot;
    logic       sel;
    logic       decon;
    logic       clr;
  } pipe_t;
  // One-hot channel to slot index; anything not one-hot maps to 7 (no slot)
  function automatic logic [2:0] ch_enc(input logic [NCH-1:0] ch);
    logic [2:0] r;
    r = 3'd7;
    for (int i = 0; i < NCH; i++)
      if ($onehot(ch) && ch[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/jt10_adpcm_fetch_pipe.sv
// jt10_adpcm_fetch_pipe: cen-advanced delay line carrying slot context to the output stage
module jt10_adpcm_fetch_pipe
  import jt10_adpcm_fetch_pkg::*;
#(
  parameter int LAT = NCH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cen,
  input  pipe_t d_i,
  output pipe_t q_o
);
  pipe_t sr_q [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
    end else if (cen) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[LAT-1];
endmodule

// File: rtl/jt10_adpcm_fetch.sv
// jt10_adpcm_fetch: ADPCM-A ROM fetch with per-channel byte buffer and
// nibble output aligned one channel rotation after the request slot
module jt10_adpcm_fetch
  import jt10_adpcm_fetch_pkg::*;
#(
  parameter int LAT = NCH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [NCH-1:0] cur_ch,
  input  logic [19:0]   addr,
  input  logic [3:0]    bank,
  input  logic          sel,
  input  logic          roe_n,
  input  logic          decon,
  input  logic          clr,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    data,
  output logic          dvalid,
  output logic          dclr,
  output logic [NCH-1:0] miss
);
  logic [2:0]     slot, tag_q, tag_d;
  logic           vslot, pend_q, pend_d;
  logic [7:0]     sbuf_q [NCH];
  logic [7:0]     sbuf_d [NCH];
  logic [NCH-1:0] miss_q, miss_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [3:0]     data_q;
  logic           dvalid_q, dclr_q;
  logic [7:0]     rd;
  pipe_t          po;
  assign slot  = ch_enc(cur_ch);
  assign vslot = slot < 3'(NCH);
  jt10_adpcm_fetch_pipe #(.LAT(LAT)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .d_i   ('{slot: slot, sel: sel, decon: decon, clr: clr}),
    .q_o   (po)
  );
  // Apply acknowledge/late-drop first, then clr, then a new request, so later rules win
  always_comb begin
    sbuf_d = sbuf_q;
    miss_d = miss_q;
    pend_d = pend_q;
    tag_d  = tag_q;
    addr_d = addr_q;
    if (pend_q && rom_ok) begin
      sbuf_d[tag_q] = rom_data;
      pend_d = 1'b0;
    end else if (cen && pend_q) begin
      miss_d[tag_q] = 1'b1;
      pend_d = 1'b0;
    end
    if (cen && clr && vslot) begin
      sbuf_d[slot] = 8'h00;
      miss_d[slot] = 1'b0;
    end
    if (cen && !roe_n && !sel && vslot) begin
      addr_d = {bank, addr};
      pend_d = 1'b1;
      tag_d  = slot;
    end
  end
  assign rd = (po.slot < 3'(NCH)) ? sbuf_q[po.slot] : 8'h00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) sbuf_q[i] <= '0;
      miss_q   <= '0;
      pend_q   <= 1'b0;
      tag_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      dclr_q   <= 1'b0;
    end else begin
      sbuf_q <= sbuf_d;
      miss_q <= miss_d;
      pend_q <= pend_d;
      tag_q  <= tag_d;
      addr_q <= addr_d;
      if (cen) begin
        data_q   <= po.sel ? rd[3:0] : rd[7:4];
        dvalid_q <= po.decon;
        dclr_q   <= po.clr;
      end
    end
  end
  assign rom_addr = addr_q;
  assign rom_cs   = pend_q;
  assign data     = data_q;
  assign dvalid   = dvalid_q;
  assign dclr     = dclr_q;
  assign miss     = miss_q;
endmodule

// File: tb/tb_jt10_adpcm_fetch.sv
// tb_jt10_adpcm_fetch: directed scenarios checked every clk against a queue-based slot model
module tb_jt10_adpcm_fetch;
  localparam int LAT = 6;
  logic        clk, rst_n, cen, sel, roe_n, decon, clr, rom_cs, rom_ok, dvalid, dclr;
  logic [5:0]  cur_ch, miss;
  logic [19:0] addr;
  logic [3:0]  bank, data;
  logic [23:0] rom_addr;
  logic [7:0]  rom_data;
  int n_chk = 0, n_fail = 0, cs_cnt = 0, cc = 0, c0;

  jt10_adpcm_fetch dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cur_ch(cur_ch), .addr(addr), .bank(bank),
    .sel(sel), .roe_n(roe_n), .decon(decon), .clr(clr), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .data(data),
    .dvalid(dvalid), .dclr(dclr), .miss(miss)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-channel bytes, one outstanding request, and a queue of slot contexts
  typedef struct { int slot; bit sel; bit dv; bit cl; } ent_t;
  ent_t        hist[$];
  logic [7:0]  mbuf [6];
  logic [5:0]  mmiss;
  logic [23:0] maddr;
  logic [3:0]  mdata;
  bit          mpend, mdv, mdclr;
  int          mtag, s;
  ent_t        e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) mbuf[i] = 0;
      mmiss = 0; maddr = 0; mdata = 0; mpend = 0; mdv = 0; mdclr = 0; mtag = 0;
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back('{0, 0, 0, 0});
    end else begin
      s = 7;
      if ($countones(cur_ch) == 1) for (int i = 0; i < 6; i++) if (cur_ch[i]) s = i;
      if (cen) begin
        e = hist.pop_front();
        mdata = (e.slot > 5) ? 4'h0 : e.sel ? mbuf[e.slot][3:0] : mbuf[e.slot][7:4];
        mdv = e.dv; mdclr = e.cl;
        hist.push_back('{s, sel, decon, clr});
      end
      if (mpend && rom_ok) begin mbuf[mtag] = rom_data; mpend = 0; end
      else if (cen && mpend) begin mmiss[mtag] = 1; mpend = 0; end
      if (cen && clr && s < 6) begin mbuf[s] = 0; mmiss[s] = 0; end
      if (cen && !roe_n && !sel && s < 6) begin maddr = {bank, addr}; mpend = 1; mtag = s; end
    end
  end

  always @(negedge clk) begin
    if (rom_cs) cs_cnt++;
    if (rst_n) begin
      chk("rom_cs", 32'(rom_cs), 32'(mpend));
      chk("rom_addr", 32'(rom_addr), 32'(maddr));
      chk("data", 32'(data), 32'(mdata));
      chk("dvalid", 32'(dvalid), 32'(mdv));
      chk("dclr", 32'(dclr), 32'(mdclr));
      chk("miss", 32'(miss), 32'(mmiss));
    end
  end

  // One cen period of 4 clk; rom_ok pulses in clk ack_at (0 = together with cen, -1 = never)
  task automatic slot(input logic [3:0] bk, input logic [19:0] ad, input logic sl,
                      input logic rn, input logic dc, input logic cl, input int ack_at,
                      input logic [7:0] rb, input logic [5:0] raw = 6'd0);
    cur_ch = (raw != 0) ? raw : 6'(1 << cc);
    cc = (cc + 1) % 6;
    bank = bk; addr = ad; sel = sl; roe_n = rn; decon = dc; clr = cl; rom_data = rb;
    for (int j = 0; j < 4; j++) begin
      cen = (j == 0);
      rom_ok = (ack_at == j);
      @(negedge clk);
    end
    rom_ok = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(4'h0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; cen = 0; cur_ch = 0; addr = 0; bank = 0; sel = 0; roe_n = 1;
    decon = 0; clr = 0; rom_data = 0; rom_ok = 0;
    repeat (2) @(negedge clk);
    chk("reset rom_cs", 32'(rom_cs), 0);
    chk("reset rom_addr", 32'(rom_addr), 0);
    chk("reset data", 32'(data), 0);
    chk("reset miss", 32'(miss), 0);
    rst_n = 1;
    // Single fetch, then low nibble from the buffered byte
    c0 = cs_cnt;
    slot(4'h2, 20'h00013, 1'b0, 1'b0, 1'b1, 1'b0, 3, 8'hA7);
    chk("fetch rom_addr", 32'(rom_addr), 32'h200013);
    chk("fetch cs clks", 32'(cs_cnt - c0), 3);
    idle(5);
    c0 = cs_cnt;
    slot(4'h2, 20'h00013, 1'b1, 1'b0, 1'b1, 1'b0, -1, 8'h00);
    chk("hi nibble", 32'(data), 32'hA);
    chk("hi dvalid", 32'(dvalid), 1);
    idle(6);
    chk("lo nibble", 32'(data), 32'h7);
    chk("lo no cs", 32'(cs_cnt - c0), 0);
    // Late ROM on ch2 while ch3 requests in the same cen
    idle(1);
    slot(4'h0, 20'h00022, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'h3C);
    idle(5);
    slot(4'h0, 20'h00022, 1'b0, 1'b0, 1'b1, 1'b0, -1, 8'h55);
    slot(4'h3, 20'h00033, 1'b0, 1'b0, 1'b1, 1'b0, 2, 8'h11);
    chk("late miss", 32'(miss), 32'h04);
    chk("late next addr", 32'(rom_addr), 32'h300033);
    idle(4);
    slot(4'h0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00);
    chk("late keeps buf", 32'(data), 32'h3);
    // clr flush of ch1
    idle(4);
    slot(4'h1, 20'h00011, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'hFF);
    idle(5);
    slot(4'h1, 20'h00011, 1'b0, 1'b0, 1'b1, 1'b0, -1, 8'h00);
    idle(5);
    chk("miss ch1 set", 32'(miss), 32'h06);
    slot(4'h0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 8'h00);
    chk("clr miss", 32'(miss), 32'h04);
    idle(5);
    slot(4'h0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00);
    chk("clr data", 32'(data), 0);
    chk("clr dclr", 32'(dclr), 1);
    // rom_ok coincides with cen for pending ch4
    idle(2);
    slot(4'h0, 20'h00044, 1'b0, 1'b0, 1'b1, 1'b0, -1, 8'h00);
    slot(4'h0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h5E);
    chk("collide miss", 32'(miss), 32'h04);
    idle(4);
    slot(4'h0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00);
    chk("collide data", 32'(data), 32'h5);
    // Non-one-hot channel select
    c0 = cs_cnt;
    slot(4'h7, 20'h00077, 1'b0, 1'b0, 1'b1, 1'b0, -1, 8'h00, 6'b000011);
    idle(5);
    chk("bad ch no cs", 32'(cs_cnt - c0), 0);
    chk("bad ch miss", 32'(miss), 32'h04);
    idle(1);
    chk("bad ch data", 32'(data), 0);
    chk("bad ch dvalid", 32'(dvalid), 1);
    // Async reset with a request outstanding
    cur_ch = 6'b000001; bank = 4'h1; addr = 20'h5; sel = 0; roe_n = 0; decon = 1; clr = 0;
    cen = 1;
    @(negedge clk);
    cen = 0;
    chk("pre-reset cs", 32'(rom_cs), 1);
    #2 rst_n = 0;
    #1 chk("async cs drop", 32'(rom_cs), 0);
    @(negedge clk);
    rst_n = 1; rom_ok = 1; rom_data = 8'h99;
    @(negedge clk);
    rom_ok = 0; cc = 0;
    idle(7);
    chk("post-reset data", 32'(data), 0);
    chk("post-reset miss", 32'(miss), 0);
    chk("post-reset cs", 32'(rom_cs), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
